// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single fixed-latency memory port.
// One transaction in flight at a time; reads hold the port until their data returns.
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wmask,
  input  logic                m0_rstrb,
  output logic                m0_ready,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wmask,
  input  logic                m1_rstrb,
  output logic                m1_ready,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wmask,
  output logic                s_rstrb,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic                busy
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(RD_LAT + 1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               last, last_nxt;
  logic               owner, owner_nxt;

  logic               req0, req1;
  logic               winner;
  logic [MASK_W-1:0]  grant_wmask;

  assign req0 = m0_rstrb | (|m0_wmask);
  assign req1 = m1_rstrb | (|m1_wmask);

  // On a tie the master that did not win last time gets the port.
  assign winner      = (req0 & req1) ? ~last : req1;
  assign grant_wmask = winner ? m1_wmask : m0_wmask;

  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;
      owner <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
      owner <= owner_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    owner_nxt = owner;
    s_addr    = m0_addr;
    s_wdata   = m0_wdata;
    s_wmask   = '0;
    s_rstrb   = 1'b0;
    m0_ready  = 1'b0;
    m1_ready  = 1'b0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    busy      = 1'b0;

    case (state)
      IDLE: begin
        if (req0 | req1) begin
          s_addr   = winner ? m1_addr  : m0_addr;
          s_wdata  = winner ? m1_wdata : m0_wdata;
          m0_ready = ~winner;
          m1_ready = winner;
          last_nxt = winner;
          // A nonzero mask makes it a write even if rstrb is also set.
          if (|grant_wmask) begin
            s_wmask = grant_wmask;
          end else begin
            s_rstrb   = 1'b1;
            cnt_nxt   = CNT_W'(RD_LAT);
            owner_nxt = winner;
            state_nxt = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        busy    = 1'b1;
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          m0_rvalid = ~owner;
          m1_rvalid = owner;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (rst) begin
      s_wmask   = '0;
      s_rstrb   = 1'b0;
      m0_ready  = 1'b0;
      m1_ready  = 1'b0;
      m0_rvalid = 1'b0;
      m1_rvalid = 1'b0;
      busy      = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: lane 0 runs RD_LAT=1, lane 1 runs RD_LAT=2, each with a memory
// model and a timestamp-based transaction model checked every cycle, plus directed checks.
`default_nettype none

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst     [2];
  logic [31:0] addr    [2][2];
  logic [31:0] wdata   [2][2];
  logic [3:0]  wmask   [2][2];
  logic        rstrb   [2][2];
  logic        ready   [2][2];
  logic        rvalid  [2][2];
  logic [31:0] rdata   [2][2];
  logic [31:0] s_addr  [2];
  logic [31:0] s_wdata [2];
  logic [3:0]  s_wmask [2];
  logic        s_rstrb [2];
  logic [31:0] s_rdata [2];
  logic        busy    [2];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  for (genvar l = 0; l < 2; l++) begin : g_lane
    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(l + 1)) dut (
      .clk(clk), .rst(rst[l]),
      .m0_addr(addr[l][0]), .m0_wdata(wdata[l][0]), .m0_wmask(wmask[l][0]),
      .m0_rstrb(rstrb[l][0]), .m0_ready(ready[l][0]), .m0_rvalid(rvalid[l][0]),
      .m0_rdata(rdata[l][0]),
      .m1_addr(addr[l][1]), .m1_wdata(wdata[l][1]), .m1_wmask(wmask[l][1]),
      .m1_rstrb(rstrb[l][1]), .m1_ready(ready[l][1]), .m1_rvalid(rvalid[l][1]),
      .m1_rdata(rdata[l][1]),
      .s_addr(s_addr[l]), .s_wdata(s_wdata[l]), .s_wmask(s_wmask[l]),
      .s_rstrb(s_rstrb[l]), .s_rdata(s_rdata[l]), .busy(busy[l])
    );
  end

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory: data for a read appears exactly RD_LAT cycles after its strobe, junk otherwise.
  int          due      [2] = '{-1, -1};
  logic [31:0] due_addr [2];

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int l = 0; l < 2; l++)
      s_rdata[l] <= (cyc == due[l]) ? memfn(due_addr[l]) : (32'hBAD0_0000 ^ 32'(cyc));
  end

  // Transaction model: the port is free from free_at onward; a read granted at
  // cycle T makes it free at T+RD_LAT+1 and returns data in cycle T+RD_LAT.
  int          free_at [2] = '{0, 0};
  bit          last_m  [2] = '{1'b1, 1'b1};
  int          owner_m [2] = '{0, 0};
  logic [31:0] raddr_m [2];

  always @(negedge clk) begin
    bit          e_rdy [2];
    bit          e_rv  [2];
    bit          e_rstrb, e_busy, chk_bus, q0, q1;
    logic [3:0]  e_wm;
    logic [31:0] e_addr, e_wd;
    int          win, lat;
    for (int l = 0; l < 2; l++) begin
      lat = l + 1;
      e_rdy = '{1'b0, 1'b0};
      e_rv  = '{1'b0, 1'b0};
      e_rstrb = 0; e_busy = 0; chk_bus = 0; e_wm = '0; e_addr = '0; e_wd = '0;
      if (rst[l]) begin
        last_m[l]  = 1'b1;
        free_at[l] = cyc + 1;
      end else if (cyc < free_at[l]) begin
        e_busy = 1;
        if (cyc == free_at[l] - 1) e_rv[owner_m[l]] = 1;
      end else begin
        q0 = rstrb[l][0] || (wmask[l][0] != 0);
        q1 = rstrb[l][1] || (wmask[l][1] != 0);
        chk_bus = 1;
        if (q0 || q1) begin
          win = (q0 && q1) ? (last_m[l] ? 0 : 1) : (q1 ? 1 : 0);
          e_addr = addr[l][win];
          e_wd   = wdata[l][win];
          e_rdy[win] = 1;
          last_m[l] = (win == 1);
          if (wmask[l][win] != 0) begin
            e_wm = wmask[l][win];
          end else begin
            e_rstrb    = 1;
            free_at[l] = cyc + lat + 1;
            owner_m[l] = win;
            raddr_m[l] = addr[l][win];
          end
        end else begin
          e_addr = addr[l][0];
          e_wd   = wdata[l][0];
        end
      end

      check($sformatf("L%0d s_rstrb", l), 32'(s_rstrb[l]), 32'(e_rstrb));
      check($sformatf("L%0d s_wmask", l), 32'(s_wmask[l]), 32'(e_wm));
      check($sformatf("L%0d busy", l), 32'(busy[l]), 32'(e_busy));
      if (chk_bus) begin
        check($sformatf("L%0d s_addr", l), s_addr[l], e_addr);
        check($sformatf("L%0d s_wdata", l), s_wdata[l], e_wd);
      end
      for (int m = 0; m < 2; m++) begin
        check($sformatf("L%0d m%0d_ready", l, m), 32'(ready[l][m]), 32'(e_rdy[m]));
        check($sformatf("L%0d m%0d_rvalid", l, m), 32'(rvalid[l][m]), 32'(e_rv[m]));
        check($sformatf("L%0d m%0d_rdata pass", l, m), rdata[l][m], s_rdata[l]);
        if (e_rv[m])
          check($sformatf("L%0d m%0d read data", l, m), rdata[l][m], memfn(raddr_m[l]));
      end

      if (!rst[l] && s_rstrb[l]) begin
        due[l]      = cyc + lat;
        due_addr[l] = s_addr[l];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int l, input int m, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] wm, input logic rs);
    addr[l][m]  = a;
    wdata[l][m] = d;
    wmask[l][m] = wm;
    rstrb[l][m] = rs;
  endtask

  task automatic clr(input int l, input int m);
    wmask[l][m] = '0;
    rstrb[l][m] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int          left [2];
    logic [31:0] na   [2];
    int          g;

    for (int l = 0; l < 2; l++) begin
      rst[l] = 1'b1;
      for (int m = 0; m < 2; m++) set_req(l, m, 32'h0, 32'h0, 4'h0, 1'b0);
    end
    tick();
    // A request during reset must not be granted.
    set_req(1, 0, 32'h44, 32'h0, 4'h0, 1'b1);
    @(negedge clk);
    check("reset m0_ready", 32'(ready[1][0]), 32'd0);
    check("reset s_rstrb", 32'(s_rstrb[1]), 32'd0);
    check("reset busy", 32'(busy[1]), 32'd0);
    tick();
    clr(1, 0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    tick();

    // 1: lone m0 read, RD_LAT=1
    set_req(0, 0, 32'h0000_0010, 32'h0, 4'h0, 1'b1);
    @(negedge clk);
    check("t1 m0_ready", 32'(ready[0][0]), 32'd1);
    check("t1 s_rstrb", 32'(s_rstrb[0]), 32'd1);
    check("t1 s_addr", s_addr[0], 32'h0000_0010);
    tick();
    clr(0, 0);
    @(negedge clk);
    check("t1 m0_rvalid", 32'(rvalid[0][0]), 32'd1);
    check("t1 m0_rdata", rdata[0][0], 32'h0010_FFEF);
    check("t1 busy", 32'(busy[0]), 32'd1);
    tick();
    set_req(0, 0, 32'h0000_0020, 32'h0, 4'h0, 1'b1);
    @(negedge clk);
    check("t1 regrant", 32'(ready[0][0]), 32'd1);
    tick();
    clr(0, 0);
    tick();

    // 2: simultaneous writes after reset, m0 first
    set_req(1, 0, 32'h100, 32'hAAAA_0000, 4'hF, 1'b0);
    set_req(1, 1, 32'h200, 32'h0000_5555, 4'hC, 1'b0);
    @(negedge clk);
    check("t2 m0_ready", 32'(ready[1][0]), 32'd1);
    check("t2 m1_ready first", 32'(ready[1][1]), 32'd0);
    check("t2 s_wmask m0", 32'(s_wmask[1]), 32'hF);
    check("t2 s_wdata m0", s_wdata[1], 32'hAAAA_0000);
    tick();
    clr(1, 0);
    @(negedge clk);
    check("t2 m1_ready", 32'(ready[1][1]), 32'd1);
    check("t2 s_wmask m1", 32'(s_wmask[1]), 32'hC);
    check("t2 s_wdata m1", s_wdata[1], 32'h0000_5555);
    tick();
    clr(1, 1);
    tick();

    // 3: continuous reads from both, RD_LAT=2, two reads each
    left = '{2, 2};
    na   = '{32'h1000, 32'h2000};
    for (int k = 0; k < 12; k++) begin
      for (int m = 0; m < 2; m++)
        if (left[m] > 0) set_req(1, m, na[m], 32'h0, 4'h0, 1'b1);
        else clr(1, m);
      @(negedge clk);
      g = (k / 3) % 2;
      if (k % 3 == 0) begin
        check($sformatf("t3 grant k%0d", k), 32'(ready[1][g]), 32'd1);
        check($sformatf("t3 other k%0d", k), 32'(ready[1][1-g]), 32'd0);
      end else begin
        check($sformatf("t3 busy k%0d", k), 32'(busy[1]), 32'd1);
      end
      if (k % 3 == 2) begin
        check($sformatf("t3 rvalid owner k%0d", k), 32'(rvalid[1][g]), 32'd1);
        check($sformatf("t3 rvalid other k%0d", k), 32'(rvalid[1][1-g]), 32'd0);
      end
      for (int m = 0; m < 2; m++)
        if (ready[1][m]) begin
          left[m]--;
          na[m] = na[m] + 32'd4;
        end
      tick();
    end
    clr(1, 0);
    clr(1, 1);
    tick();

    // 4: reset during m1 read wait drops the read
    set_req(1, 1, 32'h300, 32'h0, 4'h0, 1'b1);
    @(negedge clk);
    check("t4 m1_ready", 32'(ready[1][1]), 32'd1);
    tick();
    clr(1, 1);
    rst[1] = 1'b1;
    @(negedge clk);
    check("t4 busy in reset", 32'(busy[1]), 32'd0);
    tick();
    rst[1] = 1'b0;
    set_req(1, 0, 32'h310, 32'h1111_1111, 4'hF, 1'b0);
    set_req(1, 1, 32'h320, 32'h2222_2222, 4'hF, 1'b0);
    @(negedge clk);
    check("t4 no m1_rvalid", 32'(rvalid[1][1]), 32'd0);
    check("t4 tie m0", 32'(ready[1][0]), 32'd1);
    tick();
    clr(1, 0);
    tick();
    clr(1, 1);
    // m0 wins, then reset must restore m0 priority on the next tie
    set_req(1, 0, 32'h330, 32'h3, 4'h1, 1'b0);
    tick();
    clr(1, 0);
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    set_req(1, 0, 32'h340, 32'h4, 4'h1, 1'b0);
    set_req(1, 1, 32'h350, 32'h5, 4'h1, 1'b0);
    @(negedge clk);
    check("t4b tie after reset", 32'(ready[1][0]), 32'd1);
    tick();
    clr(1, 0);
    tick();
    clr(1, 1);
    tick();

    // 5: mask plus rstrb is a write only
    set_req(1, 0, 32'h400, 32'h1234_5678, 4'b0011, 1'b1);
    @(negedge clk);
    check("t5 m0_ready", 32'(ready[1][0]), 32'd1);
    check("t5 s_wmask", 32'(s_wmask[1]), 32'h3);
    check("t5 s_rstrb", 32'(s_rstrb[1]), 32'd0);
    tick();
    clr(1, 0);
    @(negedge clk);
    check("t5 busy", 32'(busy[1]), 32'd0);
    tick();
    @(negedge clk);
    check("t5 no rvalid", 32'(rvalid[1][0]), 32'd0);
    tick();

    // 6: m1 write waits behind m0 read
    set_req(1, 0, 32'h500, 32'h0, 4'h0, 1'b1);
    @(negedge clk);
    check("t6 m0_ready", 32'(ready[1][0]), 32'd1);
    tick();
    clr(1, 0);
    set_req(1, 1, 32'h600, 32'hCAFE_F00D, 4'hF, 1'b0);
    @(negedge clk);
    check("t6 m1 held T+1", 32'(ready[1][1]), 32'd0);
    tick();
    @(negedge clk);
    check("t6 m0_rvalid", 32'(rvalid[1][0]), 32'd1);
    check("t6 m1 held T+2", 32'(ready[1][1]), 32'd0);
    tick();
    @(negedge clk);
    check("t6 m1 granted", 32'(ready[1][1]), 32'd1);
    check("t6 s_wdata", s_wdata[1], 32'hCAFE_F00D);
    tick();
    clr(1, 1);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
